// File: rtl/seg7_capture.sv
// Captures a multiplexed 7-segment display (active-low seg/an) into a 16-bit hex frame.
// Optional err pulse on rejected samples is enabled by defining SEG7_CAPTURE_ERR_EN.
module seg7_capture #(
   parameter int unsigned STABLE_CYC = 16,
   parameter int unsigned W          = 4
) (
   input  logic         clk,
   input  logic         arst,
   input  logic [0:6]   seg,
   input  logic [W-1:0] an,
   output logic [15:0]  text,
   output logic         valid,
   output logic         err
);

   localparam int unsigned CW = $clog2(STABLE_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
   localparam logic [CW-1:0] ACC_AT  = CW'(STABLE_CYC - 1);

   typedef enum logic [1:0] {
      S_WAIT   = 2'd0,
      S_ACCEPT = 2'd1,
      S_HOLD   = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    smp_an;
   logic [6:0]      smp_seg;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [15:0]     shadow, shadow_nxt;
   logic [3:0]      mask, mask_nxt;
   logic            changed_c;
   logic            seg_ok, an_ok, wr_c;
   logic [3:0]      nib;
   logic [1:0]      dig;

   // Stability counter and accept FSM; the counter saturates so a dwell accepts only once.
   always_comb begin
      changed_c = ({an, seg} != {smp_an, smp_seg});
      cnt_nxt   = cnt;
      state_nxt = state;
      if (changed_c)
         cnt_nxt = '0;
      else if (cnt != CNT_MAX)
         cnt_nxt = cnt + CW'(1);
      case (state)
         S_WAIT:   if (!changed_c && cnt_nxt == ACC_AT) state_nxt = S_ACCEPT;
         S_ACCEPT: state_nxt = changed_c ? S_WAIT : S_HOLD;
         S_HOLD:   if (changed_c) state_nxt = S_WAIT;
         default:  state_nxt = S_WAIT;
      endcase
   end

   // Segment and anode decode of the registered sample.
   always_comb begin
      seg_ok = 1'b1;
      nib    = 4'h0;
      case (smp_seg)
         7'b0000001: nib = 4'h0;
         7'b1001111: nib = 4'h1;
         7'b0010010: nib = 4'h2;
         7'b0000110: nib = 4'h3;
         7'b1001100: nib = 4'h4;
         7'b0100100: nib = 4'h5;
         7'b0100000: nib = 4'h6;
         7'b0001111: nib = 4'h7;
         7'b0000000: nib = 4'h8;
         7'b0000100: nib = 4'h9;
         7'b0001000: nib = 4'hA;
         7'b1100000: nib = 4'hB;
         7'b0110001: nib = 4'hC;
         7'b1000010: nib = 4'hD;
         7'b0110000: nib = 4'hE;
         7'b0111000: nib = 4'hF;
         default:    seg_ok = 1'b0;
      endcase
      an_ok = 1'b1;
      dig   = 2'd0;
      case (smp_an)
         4'b1110: dig = 2'd0;
         4'b1101: dig = 2'd1;
         4'b1011: dig = 2'd2;
         4'b0111: dig = 2'd3;
         default: an_ok = 1'b0;
      endcase
      wr_c       = (state == S_ACCEPT) && an_ok && seg_ok;
      shadow_nxt = shadow;
      shadow_nxt[{dig, 2'b00} +: 4] = nib;
      mask_nxt   = mask | (4'b0001 << dig);
   end

   always_ff @(posedge clk) begin
      if (arst) begin
         state   <= S_WAIT;
         smp_an  <= '0;
         smp_seg <= '0;
         cnt     <= '0;
         shadow  <= '0;
         mask    <= '0;
         text    <= '0;
         valid   <= 1'b0;
      end else begin
         state   <= state_nxt;
         smp_an  <= an;
         smp_seg <= seg;
         cnt     <= cnt_nxt;
         valid   <= 1'b0;
         if (wr_c) begin
            shadow <= shadow_nxt;
            // Completing digit publishes the frame including itself.
            if (mask_nxt == 4'b1111) begin
               text  <= shadow_nxt;
               valid <= 1'b1;
               mask  <= '0;
            end else begin
               mask  <= mask_nxt;
            end
         end
      end
   end

`ifdef SEG7_CAPTURE_ERR_EN
   logic bad_c;
   // Blank anodes are silently ignored; any other undecodable accept is flagged.
   assign bad_c = (state == S_ACCEPT) && (smp_an != '1) && !(an_ok && seg_ok);

   always_ff @(posedge clk) begin
      if (arst) err <= 1'b0;
      else      err <= bad_c;
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: expected frames queued at stimulus, checked on valid.
module tb_seg7_capture;
   localparam int unsigned STABLE_CYC = 16;
`ifdef SEG7_CAPTURE_ERR_EN
   localparam int EXP_ERR = 2;
`else
   localparam int EXP_ERR = 0;
`endif

   localparam logic [6:0] SEG_TAB [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
   localparam logic [3:0] AN_TAB [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   logic        clk = 1'b0;
   logic        arst;
   logic [0:6]  seg;
   logic [3:0]  an;
   logic [15:0] text;
   logic        valid;
   logic        err;

   int total = 0;
   int bad   = 0;
   int nvalid = 0;
   int nerr   = 0;
   logic [15:0] exp_q [$];
   logic [15:0] mon_exp;

   always #5 clk = ~clk;

   seg7_capture #(.STABLE_CYC(STABLE_CYC), .W(4)) dut (
      .clk(clk), .arst(arst), .seg(seg), .an(an),
      .text(text), .valid(valid), .err(err));

   // Output monitor: every valid pulse must match the oldest queued frame.
   always @(negedge clk) begin
      if (valid === 1'b1) begin
         nvalid++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid text=%h", text);
         end else begin
            mon_exp = exp_q.pop_front();
            if (text !== mon_exp) begin
               bad++;
               $display("FAIL frame text=%h expected=%h", text, mon_exp);
            end
         end
      end
      if (err === 1'b1) nerr++;
   end

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      an  = a;
      seg = s;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic digit(input int pos, input int val, input int n = 20);
      drive(AN_TAB[pos], SEG_TAB[val], n);
   endtask

   task automatic test_reset();
      arst = 1'b1;
      an   = 4'($urandom);
      seg  = 7'($urandom);
      repeat (3) @(posedge clk);
      #1;
      total++; if (text !== 16'h0)  begin bad++; $display("FAIL reset_text got=%h exp=0000", text); end
      total++; if (valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
      total++; if (err !== 1'b0)    begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
      an   = 4'b1111;
      seg  = 7'b1111111;
      arst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_frame();
      int v0, lat;
      v0  = nvalid;
      lat = 0;
      digit(0, 4);
      digit(1, 3);
      digit(2, 2);
      exp_q.push_back(16'h1234);
      an  = AN_TAB[3];
      seg = SEG_TAB[1];
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (valid === 1'b1 && lat == 0) lat = i;
      end
      total++; if (lat != STABLE_CYC + 1) begin bad++; $display("FAIL latency got=%0d exp=%0d", lat, STABLE_CYC + 1); end
      total++; if (nvalid - v0 != 1) begin bad++; $display("FAIL frame_pulses got=%0d exp=1", nvalid - v0); end
      total++; if (text !== 16'h1234) begin bad++; $display("FAIL frame_hold got=%h exp=1234", text); end
   endtask

   task automatic test_hold_single();
      int v0;
      v0 = nvalid;
      digit(0, 10, 100);
      total++; if (nvalid != v0) begin bad++; $display("FAIL hold_no_valid got=%0d exp=0", nvalid - v0); end
      digit(1, 1);
      digit(2, 2);
      exp_q.push_back(16'h321A);
      digit(3, 3);
   endtask

   task automatic test_overwrite();
      digit(0, 5);
      digit(0, 9);
      digit(1, 10);
      digit(2, 11);
      exp_q.push_back(16'hCBA9);
      digit(3, 12);
   endtask

   task automatic test_glitch();
      int v0;
      v0 = nvalid;
      for (int i = 0; i < 10; i++) digit(1, (i % 2 == 0) ? 6 : 7, 10);
      drive(4'b1111, 7'b1111111, 20);
      total++; if (nvalid != v0)      begin bad++; $display("FAIL glitch_valid got=%0d exp=0", nvalid - v0); end
      total++; if (text !== 16'hCBA9) begin bad++; $display("FAIL glitch_text got=%h exp=cba9", text); end
   endtask

   task automatic test_reset_mid();
      int v0;
      digit(0, 7);
      digit(1, 6);
      digit(2, 5);
      an   = 4'b1111;
      seg  = 7'b1111111;
      arst = 1'b1;
      repeat (2) @(posedge clk); #1;
      arst = 1'b0;
      total++; if (text !== 16'h0) begin bad++; $display("FAIL midreset_text got=%h exp=0000", text); end
      v0 = nvalid;
      digit(3, 8);
      digit(2, 8);
      digit(1, 8);
      exp_q.push_back(16'h8888);
      digit(0, 8);
      total++; if (nvalid - v0 != 1) begin bad++; $display("FAIL midreset_pulses got=%0d exp=1", nvalid - v0); end
   endtask

   task automatic test_invalid();
      int e0;
      e0 = nerr;
      digit(0, 15);
      digit(1, 14);
      drive(4'b1100, SEG_TAB[8], 20);
      drive(4'b1110, 7'b1111111, 20);
      drive(4'b1111, SEG_TAB[8], 20);
      total++; if (nerr - e0 != EXP_ERR) begin bad++; $display("FAIL err_count got=%0d exp=%0d", nerr - e0, EXP_ERR); end
      digit(2, 13);
      exp_q.push_back(16'h0DEF);
      digit(3, 0);
   endtask

   task automatic test_back_to_back();
      digit(0, 1, STABLE_CYC + 2);
      digit(1, 0, STABLE_CYC + 2);
      digit(2, 15, STABLE_CYC + 2);
      exp_q.push_back(16'hAF01);
      digit(3, 10, STABLE_CYC + 2);
      digit(3, 6, STABLE_CYC + 2);
      digit(2, 5, STABLE_CYC + 2);
      digit(1, 4, STABLE_CYC + 2);
      exp_q.push_back(16'h6543);
      digit(0, 3, STABLE_CYC + 2);
      drive(4'b1111, 7'b1111111, 5);
   endtask

   initial begin
      arst = 1'b1;
      an   = 4'b1111;
      seg  = 7'b1111111;
      test_reset();
      test_frame();
      test_hold_single();
      test_overwrite();
      test_glitch();
      test_reset_mid();
      test_invalid();
      test_back_to_back();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL missing_frames pending=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
